load_store_unit: RTL and testbench

//  Data-side memory stage between the core execute stage and the dual-port RAM data port.

---
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-side memory stage: one load/store at a time, word-aligned RAM accesses,
// read-modify-write for sub-word stores, sign/zero extension for sub-word loads.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        fault;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    fault = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) fault = 1'b1;
    if (req_we && req_funct3[2]) fault = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault = 1'b1;
    if (req_addr >= 32'(MEM_BYTES)) fault = 1'b1;
  end

  // Sub-word accesses are aligned, so the byte-lane shift also positions halves.
  assign shamt     = {addr_q[1:0], 3'b000};
  assign shifted   = mem_rdata >> shamt;
  assign lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault)                                        state_nxt = RESP;
          else if (!req_we || req_funct3[1:0] != 2'b10)     state_nxt = RD;
          else                                              state_nxt = WR;
        end
      end
      RD: begin
        mem_en    = 1'b1;
        state_nxt = MERGE;
      end
      MERGE:   state_nxt = we_q ? WR : RESP;
      WR: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (fault) begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b1;
        end
      end
      // Sub-word stores reuse wdata_q to hold the merged word for the WR cycle.
      if (state == MERGE) begin
        if (we_q) begin
          wdata_q <= merged;
        end else begin
          resp_rdata <= load_val;
          resp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests checked against a byte-array memory model.
module tb_load_store_unit;
  localparam int MB = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM with a backdoor port so all writes come from one process.
  logic [31:0] ram [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_idx] <= bd_data;
    if (mem_en) begin
      if (mem_wr) begin
        ram[mem_addr[11:2]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  logic [7:0] ref_b [0:MB-1];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
    if (we && f3 >= 3'd4) return 1;
    if (a % size_of(f3) != 0) return 1;
    if (a >= MB) return 1;
    return 0;
  endfunction

  task automatic backdoor(input int widx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = widx[9:0]; bd_data = d;
    for (int i = 0; i < 4; i++) ref_b[widx*4+i] = d[8*i +: 8];
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit seen);
    lat = 0; seen = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    bit f, seen;
    int sz, lat, g, rd0, wr0, exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_data;
    f = is_fault(we, f3, a);
    sz = size_of(f3);
    exp_data = 0;
    if (f) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      for (int i = 0; i < sz; i++) exp_data = exp_data | (32'(ref_b[a+i]) << (8*i));
      if (f3 == 3'd0 && exp_data[7])  exp_data = exp_data | 32'hFFFF_FF00;
      if (f3 == 3'd1 && exp_data[15]) exp_data = exp_data | 32'hFFFF_0000;
    end else begin
      exp_lat = (sz == 4) ? 2 : 4; exp_rd = (sz == 4) ? 0 : 1; exp_wr = 1;
      for (int i = 0; i < sz; i++) ref_b[a+i] = wd[8*i +: 8];
    end
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    wait_resp(lat, seen);
    chk("resp_seen", {31'h0, seen}, 32'h1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", resp_rdata, exp_data);
    chk("err", {31'h0, resp_err}, {31'h0, f});
    @(negedge clk);
    chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
    chk("rd_count", 32'(rd_cnt - rd0), 32'(exp_rd));
    chk("wr_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (we && !f) chk("ram_word", ram[a[11:2]], ref_word(a));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [31:0] a, old20;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    for (int w = 0; w < 32; w++) backdoor(w, (w == 4) ? 32'hDEADBEEF : $urandom);
    for (int w = 1016; w < 1024; w++) backdoor(w, $urandom);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);

    // Word / sub-word loads of 0xDEADBEEF at 0x10
    do_req(0, 3'd2, 32'h10, 0);
    do_req(0, 3'd0, 32'h13, 0);
    do_req(0, 3'd4, 32'h13, 0);
    do_req(0, 3'd1, 32'h12, 0);
    do_req(0, 3'd5, 32'h10, 0);
    // Read-modify-write stores
    do_req(1, 3'd0, 32'h11, 32'h12345678);
    chk("sb_word", ram[4], 32'hDEAD78EF);
    do_req(1, 3'd1, 32'h12, 32'hAAAA5555);
    chk("sh_word", ram[4], 32'h555578EF);
    // Faults
    do_req(0, 3'd2, 32'h02, 0);
    do_req(0, 3'd1, 32'h01, 0);
    do_req(0, 3'd3, 32'h10, 0);
    do_req(1, 3'd2, 32'h1000, 32'h1);
    do_req(1, 3'd4, 32'h10, 32'h1);
    do_req(0, 3'd2, 32'hFFC, 0);
    do_req(0, 3'd0, 32'hFFF, 0);

    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 127));
      else if (r == 8) a = 32'($urandom_range(4064, 4095));
      else             a = (r[0] ? 32'($urandom_range(4096, 4200)) : $urandom);
      do_req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom);
    end

    // req_valid held high across two loads
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h14;
    lat = 0; seen = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      chk("busy_ready", {31'h0, req_ready}, 32'h0);
      if (resp_valid) seen = 1;
    end
    chk("b2b_lat1", 32'(lat), 32'd3);
    chk("b2b_data1", resp_rdata, ref_word(32'h10));
    @(negedge clk);
    chk("b2b_ready_after_resp", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat, seen);
    chk("b2b_lat2", 32'(lat), 32'd3);
    chk("b2b_data2", resp_rdata, ref_word(32'h14));

    // Reset during the write cycle of SW 0x20
    old20 = ref_word(32'h20);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = ~old20 ^ 32'h0F0F_0000;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wr_cycle", {31'h0, mem_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mid_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_rdata", resp_rdata, 32'h0);
    chk("rst_mid_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    chk("rst_word20", ram[8], old20);
    do_req(0, 3'd2, 32'h20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
